// File: rtl/gpio_pkg.sv
// Shared register map and offset decode for the multichannel GPIO core.
package gpio_pkg;

  localparam int          GPIO_MAX_CHANNELS = 8;
  localparam logic [11:0] GPIO_CH_STRIDE    = 12'h020;

  localparam logic [4:0]  GPIO_DATA_OFS     = 5'h00;
  localparam logic [4:0]  GPIO_TRI_OFS      = 5'h04;
  localparam logic [4:0]  GPIO_IN_OFS       = 5'h08;
  localparam logic [4:0]  GPIO_RISE_EN_OFS  = 5'h0C;
  localparam logic [4:0]  GPIO_FALL_EN_OFS  = 5'h10;
  localparam logic [4:0]  GPIO_ISR_OFS      = 5'h14;

  localparam logic [11:0] GPIO_GIER_ADDR    = 12'h200;
  localparam logic [11:0] GPIO_IPISR_ADDR   = 12'h204;

  // Word index within a channel window; the two trailing codes are holes in the map.
  typedef enum logic [2:0] {
    REG_DATA    = GPIO_DATA_OFS[4:2],
    REG_TRI     = GPIO_TRI_OFS[4:2],
    REG_IN      = GPIO_IN_OFS[4:2],
    REG_RISE_EN = GPIO_RISE_EN_OFS[4:2],
    REG_FALL_EN = GPIO_FALL_EN_OFS[4:2],
    REG_ISR     = GPIO_ISR_OFS[4:2],
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } gpio_reg_e;

  function automatic gpio_reg_e decode_reg(input logic [4:0] ofs);
    return gpio_reg_e'(ofs[4:2]);
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: output/tri-state registers, input synchroniser, edge capture into W1C ISR.
module gpio_channel
  import gpio_pkg::*;
#(
  parameter int C_GPIO_WIDTH  = 32,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_data,
  input  logic                    wr_tri,
  input  logic                    wr_rise_en,
  input  logic                    wr_fall_en,
  input  logic                    wr_isr,
  input  logic [C_GPIO_WIDTH-1:0] wdata,
  input  gpio_reg_e               rd_reg,
  output logic [C_GPIO_WIDTH-1:0] rd_data,
  input  logic [C_GPIO_WIDTH-1:0] pad_i,
  output logic [C_GPIO_WIDTH-1:0] pad_o,
  output logic [C_GPIO_WIDTH-1:0] pad_t,
  output logic [C_GPIO_WIDTH-1:0] isr
);

  localparam int W = C_GPIO_WIDTH;

  logic [W-1:0] data_q, tri_q, rise_en_q, fall_en_q, isr_q;
  logic [W-1:0] sync_q [C_SYNC_STAGES];
  logic [W-1:0] prev_q;
  logic [W-1:0] sync_v, rise, fall, w1c_mask;

  assign sync_v   = sync_q[C_SYNC_STAGES-1];
  assign rise     = sync_v & ~prev_q;
  assign fall     = ~sync_v & prev_q;
  assign w1c_mask = wr_isr ? wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage take the previous stage's old value,
      // so the chain really is C_SYNC_STAGES flops deep regardless of statement order.
      sync_q[0] <= pad_i;
      for (int i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      tri_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      isr_q     <= '0;
    end else begin
      if (wr_data)    data_q    <= wdata;
      if (wr_tri)     tri_q     <= wdata;
      if (wr_rise_en) rise_en_q <= wdata;
      if (wr_fall_en) fall_en_q <= wdata;
      // A fresh edge in the same cycle as its W1C keeps the bit set.
      isr_q <= (isr_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    unique case (rd_reg)
      REG_DATA:    rd_data = data_q;
      REG_TRI:     rd_data = tri_q;
      REG_IN:      rd_data = sync_v;
      REG_RISE_EN: rd_data = rise_en_q;
      REG_FALL_EN: rd_data = fall_en_q;
      REG_ISR:     rd_data = isr_q;
      default:     rd_data = '0;
    endcase
  end

  assign pad_o = data_q;
  assign pad_t = tri_q;
  assign isr   = isr_q;

endmodule

// File: rtl/gpio_multichannel_core.sv
// N-channel GPIO core: address decode, registered read mux, global interrupt enable and IRQ tree.
module gpio_multichannel_core
  import gpio_pkg::*;
#(
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_GPIO_WIDTH   = 32,
  parameter int C_SYNC_STAGES  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   reg_wr_en,
  input  logic                                   reg_rd_en,
  input  logic [11:0]                            reg_addr,
  input  logic [31:0]                            reg_wdata,
  output logic [31:0]                            reg_rdata,
  output logic                                   reg_rd_valid,
  output logic                                   reg_err,
  input  logic [C_NUM_CHANNELS*C_GPIO_WIDTH-1:0] gpio_io_i,
  output logic [C_NUM_CHANNELS*C_GPIO_WIDTH-1:0] gpio_io_o,
  output logic [C_NUM_CHANNELS*C_GPIO_WIDTH-1:0] gpio_io_t,
  output logic                                   ip2intc_irpt
);

  localparam int N = C_NUM_CHANNELS;
  localparam int W = C_GPIO_WIDTH;

  logic [3:0]          acc_ch;
  gpio_reg_e           acc_reg;
  logic                ch_hit, gier_hit, ipisr_hit, mapped;
  logic [N-1:0]        wr_ch;
  logic [N-1:0]        isr_any;
  logic [W-1:0]        ch_rd_data [N];
  logic [31:0]         rd_word;
  logic                gier_q;
  logic                unused_bits;

  assign unused_bits = ^{reg_addr[1:0], reg_wdata};

  // Channel windows fill 0x000..0x1FF; channel index is the stride-sized slot number.
  assign acc_ch    = reg_addr[8:5];
  assign acc_reg   = decode_reg(reg_addr[4:0]);
  assign ch_hit    = (reg_addr < GPIO_GIER_ADDR) && (int'(acc_ch) < N) && (acc_reg <= REG_ISR);
  assign gier_hit  = {reg_addr[11:2], 2'b00} == GPIO_GIER_ADDR;
  assign ipisr_hit = {reg_addr[11:2], 2'b00} == GPIO_IPISR_ADDR;
  assign mapped    = ch_hit | gier_hit | ipisr_hit;

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [W-1:0] ch_isr;

    assign wr_ch[c] = reg_wr_en && ch_hit && (acc_ch == 4'(c));

    gpio_channel #(
      .C_GPIO_WIDTH (W),
      .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_data   (wr_ch[c] && acc_reg == REG_DATA),
      .wr_tri    (wr_ch[c] && acc_reg == REG_TRI),
      .wr_rise_en(wr_ch[c] && acc_reg == REG_RISE_EN),
      .wr_fall_en(wr_ch[c] && acc_reg == REG_FALL_EN),
      .wr_isr    (wr_ch[c] && acc_reg == REG_ISR),
      .wdata     (reg_wdata[W-1:0]),
      .rd_reg    (acc_reg),
      .rd_data   (ch_rd_data[c]),
      .pad_i     (gpio_io_i[c*W +: W]),
      .pad_o     (gpio_io_o[c*W +: W]),
      .pad_t     (gpio_io_t[c*W +: W]),
      .isr       (ch_isr)
    );

    assign isr_any[c] = |ch_isr;
  end

  always_comb begin
    rd_word = '0;
    if (gier_hit) begin
      rd_word[0] = gier_q;
    end else if (ipisr_hit) begin
      rd_word[N-1:0] = isr_any;
    end else if (ch_hit) begin
      for (int c = 0; c < N; c++) begin
        if (acc_ch == 4'(c)) rd_word[W-1:0] = ch_rd_data[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gier_q       <= 1'b0;
      reg_rdata    <= '0;
      reg_rd_valid <= 1'b0;
      reg_err      <= 1'b0;
      ip2intc_irpt <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      reg_err      <= (reg_rd_en | reg_wr_en) & ~mapped;
      if (reg_rd_en) reg_rdata <= rd_word;
      if (reg_wr_en && gier_hit) gier_q <= reg_wdata[0];
      ip2intc_irpt <= gier_q & (|isr_any);
    end
  end

endmodule

// File: tb/tb_gpio_multichannel_core.sv
// Directed bench for gpio_multichannel_core with a register-map level reference model.
module tb_gpio_multichannel_core;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int NW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          reg_wr_en = 1'b0;
  logic          reg_rd_en = 1'b0;
  logic [11:0]   reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          reg_rd_valid;
  logic          reg_err;
  logic [NW-1:0] gpio_io_i = '0;
  logic [NW-1:0] gpio_io_o;
  logic [NW-1:0] gpio_io_t;
  logic          ip2intc_irpt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  gpio_multichannel_core #(
    .C_NUM_CHANNELS(N),
    .C_GPIO_WIDTH  (W),
    .C_SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_rd_valid(reg_rd_valid),
    .reg_err     (reg_err),
    .gpio_io_i   (gpio_io_i),
    .gpio_io_o   (gpio_io_o),
    .gpio_io_t   (gpio_io_t),
    .ip2intc_irpt(ip2intc_irpt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  m_data [N], m_tri [N], m_rise [N], m_fall [N], m_isr [N];
  logic          m_gier;
  logic [NW-1:0] m_smp [S+1];  // m_smp[j]: pad value sampled j+1 edges ago
  logic [31:0]   m_rdata;
  logic          m_valid, m_err, m_irpt;
  logic [W-1:0]  m_set [N];

  function automatic bit is_mapped(input logic [11:0] addr);
    int a = int'({addr[11:2], 2'b00});
    if (a == 'h200 || a == 'h204) return 1'b1;
    if (a < 'h200) return (a / 32 < N) && (a % 32 <= 'h14);
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    int a = int'({addr[11:2], 2'b00});
    int c = a / 32;
    logic [31:0] v = '0;
    if (!is_mapped(addr)) return '0;
    if (a == 'h200) return {31'd0, m_gier};
    if (a == 'h204) begin
      for (int k = 0; k < N; k++) v[k] = |m_isr[k];
      return v;
    end
    case (a % 32)
      'h00: v = 32'(m_data[c]);
      'h04: v = 32'(m_tri[c]);
      'h08: v = 32'(m_smp[S-1][c*W +: W]);
      'h0C: v = 32'(m_rise[c]);
      'h10: v = 32'(m_fall[c]);
      'h14: v = 32'(m_isr[c]);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [11:0] addr, input logic [31:0] d);
    int a = int'({addr[11:2], 2'b00});
    int c = a / 32;
    if (!is_mapped(addr)) return;
    if (a == 'h200) begin m_gier = d[0]; return; end
    if (a >= 'h200) return;
    case (a % 32)
      'h00: m_data[c] = d[W-1:0];
      'h04: m_tri[c]  = d[W-1:0];
      'h0C: m_rise[c] = d[W-1:0];
      'h10: m_fall[c] = d[W-1:0];
      'h14: m_isr[c]  = m_isr[c] & ~d[W-1:0];
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_data[c] = '0; m_tri[c] = '1; m_rise[c] = '0; m_fall[c] = '0; m_isr[c] = '0;
      end
      for (int j = 0; j <= S; j++) m_smp[j] = '0;
      m_gier = 1'b0; m_rdata = '0; m_valid = 1'b0; m_err = 1'b0; m_irpt = 1'b0;
    end else begin
      m_irpt = 1'b0;
      for (int c = 0; c < N; c++) if (m_isr[c] != '0) m_irpt = m_gier;
      m_valid = reg_rd_en;
      m_err   = (reg_rd_en || reg_wr_en) && !is_mapped(reg_addr);
      if (reg_rd_en) m_rdata = model_read(reg_addr);
      for (int c = 0; c < N; c++) begin
        logic [W-1:0] now_v, old_v;
        now_v = m_smp[S-1][c*W +: W];
        old_v = m_smp[S][c*W +: W];
        m_set[c] = (now_v & ~old_v & m_rise[c]) | (~now_v & old_v & m_fall[c]);
      end
      if (reg_wr_en) model_write(reg_addr, reg_wdata);
      for (int c = 0; c < N; c++) m_isr[c] = m_isr[c] | m_set[c];
      for (int j = S; j > 0; j--) m_smp[j] = m_smp[j-1];
      m_smp[0] = gpio_io_i;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [NW-1:0] eo, et;
      for (int c = 0; c < N; c++) begin
        eo[c*W +: W] = m_data[c];
        et[c*W +: W] = m_tri[c];
      end
      check("cmp_gpio_o", 64'(gpio_io_o), 64'(eo));
      check("cmp_gpio_t", 64'(gpio_io_t), 64'(et));
      check("cmp_irpt", 64'(ip2intc_irpt), 64'(m_irpt));
      check("cmp_rd_valid", 64'(reg_rd_valid), 64'(m_valid));
      check("cmp_err", 64'(reg_err), 64'(m_err));
      check("cmp_rdata", 64'(reg_rdata), 64'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr_en = 1'b1;
    @(posedge clk); #2;
    reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    reg_addr = a; reg_rd_en = 1'b1;
    @(posedge clk); #2;
    reg_rd_en = 1'b0;
    d = reg_rdata;
  endtask

  task automatic rdwr(input logic [11:0] a, input logic [31:0] wd, output logic [31:0] d);
    reg_addr = a; reg_wdata = wd; reg_wr_en = 1'b1; reg_rd_en = 1'b1;
    @(posedge clk); #2;
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    d = reg_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [11:0] reset_addrs [8];
    logic [31:0] reset_exp [8];
    reset_addrs = '{12'h000, 12'h004, 12'h014, 12'h020, 12'h024, 12'h034, 12'h200, 12'h204};
    reset_exp   = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_on = 1'b1;

    // 1: reset values
    check("rst_irpt", 64'(ip2intc_irpt), 64'h0);
    check("rst_gpio_t", 64'(gpio_io_t), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_rdata", 64'(reg_rdata), 64'h0);
    for (int i = 0; i < 8; i++) begin
      rd(reset_addrs[i], d);
      check($sformatf("rst_read_%03h", reset_addrs[i]), 64'(d), 64'(reset_exp[i]));
    end

    // 2: channel 1 data/tri, visible on pads the same edge
    wr(12'h020, 32'hA5A5_5A5A);
    check("ch1_data_pad", 64'(gpio_io_o[63:32]), 64'hA5A5_5A5A);
    wr(12'h024, 32'h0);
    check("ch1_tri_pad", 64'(gpio_io_t[63:32]), 64'h0);
    rd(12'h020, d);
    check("ch1_data_read", 64'(d), 64'hA5A5_5A5A);
    rdwr(12'h000, 32'h0000_1234, d);
    check("rdwr_old_value", 64'(d), 64'h0);
    rd(12'h000, d);
    check("rdwr_new_value", 64'(d), 64'h0000_1234);

    // 3: rising edge interrupt latency and W1C
    wr(12'h00C, 32'h1);
    wr(12'h200, 32'h1);
    gpio_io_i[0] = 1'b1;
    idle(2);
    rd(12'h014, d);
    check("isr_before_edge3", 64'(d), 64'h0);
    check("irpt_edge3", 64'(ip2intc_irpt), 64'h0);
    rd(12'h014, d);
    check("isr_after_edge3", 64'(d), 64'h1);
    check("irpt_edge4", 64'(ip2intc_irpt), 64'h1);
    rd(12'h008, d);
    check("in_reads_sync", 64'(d), 64'h1);
    wr(12'h014, 32'h1);
    check("irpt_w1c_plus1", 64'(ip2intc_irpt), 64'h1);
    idle(1);
    check("irpt_w1c_plus2", 64'(ip2intc_irpt), 64'h0);

    // 4: falling edge on ch1 bit5 coinciding with its W1C
    wr(12'h030, 32'h20);
    gpio_io_i[37] = 1'b1;
    idle(5);
    gpio_io_i[37] = 1'b0;
    idle(5);
    rd(12'h034, d);
    check("fall_isr_set", 64'(d), 64'h20);
    wr(12'h034, 32'h20);
    gpio_io_i[37] = 1'b1;
    idle(5);
    gpio_io_i[37] = 1'b0;
    idle(2);
    wr(12'h034, 32'h20);
    rd(12'h034, d);
    check("set_wins_over_clear", 64'(d), 64'h20);
    wr(12'h034, 32'h20);
    rd(12'h034, d);
    check("plain_clear", 64'(d), 64'h0);

    // 5: unmapped accesses
    rd(12'h1FC, d);
    check("unmapped_rdata", 64'(d), 64'h0);
    check("unmapped_err", 64'(reg_err), 64'h1);
    idle(1);
    check("err_one_cycle", 64'(reg_err), 64'h0);
    wr(12'h040, 32'hDEAD_BEEF);
    check("ch2_wr_err", 64'(reg_err), 64'h1);
    rd(12'h040, d);
    check("ch2_rdata", 64'(d), 64'h0);
    wr(12'h008, 32'hFFFF_FFFF);
    check("in_wr_no_err", 64'(reg_err), 64'h0);
    wr(12'h204, 32'hFFFF_FFFF);
    check("ipisr_wr_no_err", 64'(reg_err), 64'h0);
    rd(12'h208, d);
    check("above_map_err", 64'(reg_err), 64'h1);

    // 6: asynchronous reset with an interrupt pending
    gpio_io_i[0] = 1'b0;
    idle(5);
    gpio_io_i[0] = 1'b1;
    idle(5);
    check("irpt_before_reset", 64'(ip2intc_irpt), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_irpt", 64'(ip2intc_irpt), 64'h0);
    check("async_gpio_t", 64'(gpio_io_t), 64'hFFFF_FFFF_FFFF_FFFF);
    check("async_gpio_o", 64'(gpio_io_o), 64'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    rd(12'h014, d);
    check("post_reset_isr", 64'(d), 64'h0);
    rd(12'h024, d);
    check("post_reset_tri", 64'(d), 64'hFFFF_FFFF);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
